// File: rtl/char_plot_if.sv
// Pixel-plot sequencer port bundle: request side, font ROM side and VGA pixel-write side.
// master = requester/ROM/VGA environment, slave = char_plot_ctrl.
interface char_plot_if;
  logic       draw_req;
  logic [5:0] draw_col;
  logic [4:0] draw_row;
  logic [6:0] draw_char;
  logic [2:0] fg;
  logic [2:0] bg;
  logic       clear_req;
  logic [2:0] clear_colour;
  logic [9:0] font_addr;
  logic [7:0] font_data;
  logic       ready;
  logic       done;
  logic [8:0] x;
  logic [8:0] y;
  logic [2:0] colour;
  logic       writeEn;

  modport master (
    output draw_req, draw_col, draw_row, draw_char, fg, bg,
    output clear_req, clear_colour, font_data,
    input  font_addr, ready, done, x, y, colour, writeEn
  );

  modport slave (
    input  draw_req, draw_col, draw_row, draw_char, fg, bg,
    input  clear_req, clear_colour, font_data,
    output font_addr, ready, done, x, y, colour, writeEn
  );
endinterface

// File: rtl/char_plot_ctrl.sv
// Glyph-draw / screen-clear sequencer for a 320x240 3-bit VGA pixel-write port.
// Optional: define TRANSPARENT_BG_EN to suppress writes for glyph bits that are 0.
module char_plot_ctrl #(
  parameter int unsigned FONT_LAT = 1
) (
  input logic       CLOCK_50,
  input logic       reset,
  char_plot_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_PLOT  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // FETCH holds the address for the ROM latency before LOAD captures the row.
  localparam logic [1:0] FETCH_LAST = 2'(FONT_LAT - 1);

  logic [2:0] state_q, state_d;
  logic [5:0] col_q,   col_d;
  logic [4:0] row_q,   row_d;
  logic [6:0] char_q,  char_d;
  logic [2:0] fg_q,    fg_d;
  logic [2:0] bg_q,    bg_d;
  logic [2:0] clr_q,   clr_d;
  logic [2:0] r_q,     r_d;
  logic [2:0] p_q,     p_d;
  logic [1:0] lat_q,   lat_d;
  logic [7:0] sr_q,    sr_d;
  logic [8:0] cx_q,    cx_d;
  logic [8:0] cy_q,    cy_d;
  logic [8:0] x_q,     x_d;
  logic [8:0] y_q,     y_d;
  logic [2:0] colour_q, colour_d;
  logic       we_q,    we_d;

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    char_d   = char_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    clr_d    = clr_q;
    r_d      = r_q;
    p_d      = p_q;
    lat_d    = lat_q;
    sr_d     = sr_q;
    cx_d     = cx_q;
    cy_d     = cy_q;

    case (state_q)
      S_IDLE: begin
        if (bus.clear_req) begin
          clr_d   = bus.clear_colour;
          cx_d    = '0;
          cy_d    = '0;
          state_d = S_CLEAR;
        end else if (bus.draw_req) begin
          col_d   = bus.draw_col;
          row_d   = bus.draw_row;
          char_d  = bus.draw_char;
          fg_d    = bus.fg;
          bg_d    = bus.bg;
          r_d     = '0;
          lat_d   = '0;
          state_d = (bus.draw_col > 6'd39 || bus.draw_row > 5'd29) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (lat_q == FETCH_LAST) begin
          lat_d   = '0;
          state_d = S_LOAD;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_LOAD: begin
        sr_d    = bus.font_data;
        p_d     = '0;
        state_d = S_PLOT;
      end
      S_PLOT: begin
        sr_d = {sr_q[6:0], 1'b0};
        if (p_q == 3'd7) begin
          p_d = '0;
          if (r_q == 3'd7) begin
            r_d     = '0;
            state_d = S_DONE;
          end else begin
            r_d     = r_q + 3'd1;
            state_d = S_FETCH;
          end
        end else begin
          p_d = p_q + 3'd1;
        end
      end
      S_CLEAR: begin
        if (cx_q == 9'd319) begin
          cx_d = '0;
          if (cy_q == 9'd239) begin
            cy_d    = '0;
            state_d = S_DONE;
          end else begin
            cy_d = cy_q + 9'd1;
          end
        end else begin
          cx_d = cx_q + 9'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pixel outputs are registered from the next-state values so they line up with PLOT/CLEAR cycles.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    we_d     = 1'b0;
    if (state_d == S_PLOT) begin
      x_d      = {col_q, p_d};
      y_d      = {1'b0, row_q, r_d};
      colour_d = sr_d[7] ? fg_q : bg_q;
`ifdef TRANSPARENT_BG_EN
      we_d     = sr_d[7];
`else
      we_d     = 1'b1;
`endif
    end else if (state_d == S_CLEAR) begin
      x_d      = cx_d;
      y_d      = cy_d;
      colour_d = clr_d;
      we_d     = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; all next values come from the comb blocks.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      char_q   <= '0;
      fg_q     <= '0;
      bg_q     <= '0;
      clr_q    <= '0;
      r_q      <= '0;
      p_q      <= '0;
      lat_q    <= '0;
      sr_q     <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      char_q   <= char_d;
      fg_q     <= fg_d;
      bg_q     <= bg_d;
      clr_q    <= clr_d;
      r_q      <= r_d;
      p_q      <= p_d;
      lat_q    <= lat_d;
      sr_q     <= sr_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      we_q     <= we_d;
    end
  end

  assign bus.font_addr = {char_q, r_q};
  assign bus.ready     = (state_q == S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.colour    = colour_q;
  assign bus.writeEn   = we_q;

endmodule

// File: tb/tb_char_plot_ctrl.sv
// Self-checking bench for char_plot_ctrl: directed and randomized draws/clears against a
// cycle-indexed behavioural model of the glyph and raster-scan write pattern.
module tb_char_plot_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  char_plot_if bus();

  char_plot_ctrl #(.FONT_LAT(1)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #10 clk = ~clk;

`ifdef TRANSPARENT_BG_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic [7:0] rom [1024];
  always @(posedge clk) bus.font_data <= rom[bus.font_addr];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.draw_req  = 1'b0;
    bus.clear_req = 1'b0;
  endtask

  task automatic noise_inputs();
    bus.draw_req     = 1'($urandom_range(0, 1));
    bus.clear_req    = 1'($urandom_range(0, 1));
    bus.draw_col     = 6'($urandom);
    bus.draw_row     = 5'($urandom);
    bus.draw_char    = 7'($urandom);
    bus.fg           = 3'($urandom);
    bus.bg           = 3'($urandom);
    bus.clear_colour = 3'($urandom);
  endtask

  // Cycle c after the accept edge: row r = (c-1)/10; phase 0 = FETCH, 1 = LOAD, 2..9 = pixel p.
  task automatic run_draw(input logic [5:0] col, input logic [4:0] row, input logic [6:0] ch,
                          input logic [2:0] fg, input logic [2:0] bg,
                          input bit noisy, input int reset_at);
    bus.draw_col  = col;
    bus.draw_row  = row;
    bus.draw_char = ch;
    bus.fg        = fg;
    bus.bg        = bg;
    bus.draw_req  = 1'b1;
    bus.clear_req = 1'b0;
    for (int c = 1; c <= 82; c++) begin
      int gr, ph, p;
      bit pix, exp_we;
      logic [9:0] a;
      next_cycle();
      gr = (c - 1) / 10;
      ph = (c - 1) % 10;
      p = ph - 2;
      exp_we = 1'b0;
      pix = 1'b0;
      if (c <= 80 && ph >= 2) begin
        a = {ch, 3'(gr)};
        pix = rom[a][7 - p];
        exp_we = pix || !TRANSP;
      end
      check("draw_writeEn", 16'(bus.writeEn), 16'(exp_we));
      if (exp_we) begin
        check("draw_x", 16'(bus.x), 16'(col * 8 + p));
        check("draw_y", 16'(bus.y), 16'(row * 8 + gr));
        check("draw_colour", 16'(bus.colour), 16'(pix ? fg : bg));
      end
      if (c <= 80 && ph == 0) check("draw_font_addr", 16'(bus.font_addr), 16'({ch, 3'(gr)}));
      check("draw_ready", 16'(bus.ready), 16'(c == 82));
      check("draw_done", 16'(bus.done), 16'(c == 81));
      if (c == reset_at) begin
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        check("rst_writeEn", 16'(bus.writeEn), 16'd0);
        check("rst_ready", 16'(bus.ready), 16'd1);
        check("rst_done", 16'(bus.done), 16'd0);
        for (int i = 0; i < 5; i++) begin
          next_cycle();
          check("rst_no_done", 16'(bus.done), 16'd0);
          check("rst_no_write", 16'(bus.writeEn), 16'd0);
        end
        return;
      end
      if (noisy && c <= 80) noise_inputs();
      else idle_inputs();
    end
  endtask

  task automatic run_oob(input logic [5:0] col, input logic [4:0] row);
    bus.draw_col  = col;
    bus.draw_row  = row;
    bus.draw_char = 7'($urandom);
    bus.draw_req  = 1'b1;
    bus.clear_req = 1'b0;
    next_cycle();
    idle_inputs();
    check("oob_done_c1", 16'(bus.done), 16'd1);
    check("oob_writeEn_c1", 16'(bus.writeEn), 16'd0);
    check("oob_ready_c1", 16'(bus.ready), 16'd0);
    next_cycle();
    check("oob_ready_c2", 16'(bus.ready), 16'd1);
    check("oob_done_c2", 16'(bus.done), 16'd0);
    check("oob_writeEn_c2", 16'(bus.writeEn), 16'd0);
  endtask

  task automatic run_clear(input logic [2:0] fill);
    bus.clear_colour = fill;
    bus.clear_req    = 1'b1;
    bus.draw_req     = 1'b1;
    bus.draw_col     = 6'd5;
    bus.draw_row     = 5'd5;
    for (int c = 1; c <= 76804; c++) begin
      bit exp_we;
      next_cycle();
      if (c == 1) begin
        idle_inputs();
        bus.clear_colour = 3'($urandom);
      end
      exp_we = (c <= 76800);
      check("clr_writeEn", 16'(bus.writeEn), 16'(exp_we));
      if (exp_we) begin
        check("clr_x", 16'(bus.x), 16'((c - 1) % 320));
        check("clr_y", 16'(bus.y), 16'((c - 1) / 320));
        check("clr_colour", 16'(bus.colour), 16'(fill));
      end
      check("clr_done", 16'(bus.done), 16'(c == 76801));
      check("clr_ready", 16'(bus.ready), 16'(c >= 76802));
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
    rom[{7'h41, 3'd0}] = 8'h18;
    for (int i = 1; i < 8; i++) rom[{7'h41, 3'(i)}] = 8'h00;
    for (int i = 0; i < 8; i++) rom[{7'h7f, 3'(i)}] = 8'h81;

    bus.draw_req = 1'b0;
    bus.clear_req = 1'b0;
    bus.draw_col = '0;
    bus.draw_row = '0;
    bus.draw_char = '0;
    bus.fg = '0;
    bus.bg = '0;
    bus.clear_colour = '0;

    reset = 1'b1;
    next_cycle();
    next_cycle();
    check("reset_ready", 16'(bus.ready), 16'd1);
    check("reset_done", 16'(bus.done), 16'd0);
    check("reset_writeEn", 16'(bus.writeEn), 16'd0);
    check("reset_x", 16'(bus.x), 16'd0);
    check("reset_y", 16'(bus.y), 16'd0);
    check("reset_colour", 16'(bus.colour), 16'd0);
    check("reset_font_addr", 16'(bus.font_addr), 16'd0);
    reset = 1'b0;
    next_cycle();

    run_draw(6'd0, 5'd0, 7'h41, 3'd7, 3'd0, 1'b0, 0);
    run_draw(6'd39, 5'd29, 7'($urandom), 3'($urandom), 3'($urandom), 1'b1, 0);
    run_draw(6'd10, 5'd3, 7'h7f, 3'd2, 3'd5, 1'b0, 0);
    for (int n = 0; n < 4; n++)
      run_draw(6'($urandom_range(0, 39)), 5'($urandom_range(0, 29)), 7'($urandom),
               3'($urandom), 3'($urandom), 1'b1, 0);

    run_oob(6'd40, 5'd0);
    run_oob(6'($urandom_range(0, 39)), 5'd30);
    run_oob(6'd63, 5'd31);

    run_draw(6'd7, 5'd9, 7'($urandom), 3'd6, 3'd1, 1'b0, 40);
    run_draw(6'd20, 5'd15, 7'($urandom), 3'd3, 3'd4, 1'b1, 0);

    run_clear(3'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/char_plot_ctrl.md
# char_plot_ctrl

Sequencer that drives the 320x240, 3-bit-colour VGA pixel-write port (x, y, colour, plot) for the text editor. It renders one 8x8 glyph into a 40x30 character-cell grid from a synchronous font ROM, or fills the whole screen with one colour. It arbitrates between glyph-draw and clear requests, holding each operation until it completes.

## Interface
Parameters:
- FONT_LAT, 1, font ROM read latency in cycles; only 1 is supported.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- draw_req  in  1  glyph-draw request; sampled only while ready=1.
- draw_col  in  6  cell column, valid range 0..39.
- draw_row  in  5  cell row, valid range 0..29.
- draw_char  in  7  character code.
- fg  in  3  foreground colour.
- bg  in  3  background colour.
- clear_req  in  1  screen-clear request; sampled only while ready=1.
- clear_colour  in  3  fill colour.
- font_addr  out  10  font ROM address, {draw_char, glyph_row[2:0]}.
- font_data  in  8  ROM row bits; bit 7 is the leftmost pixel; valid 1 cycle after font_addr.
- ready  out  1  high in IDLE; a request is accepted on an edge where ready=1.
- done  out  1  one-cycle pulse when an operation completes.
- x  out  9  pixel x to the VGA adapter.
- y  out  9  pixel y to the VGA adapter.
- colour  out  3  pixel colour to the VGA adapter.
- writeEn  out  1  pixel write strobe to the VGA adapter.

## Operation
- States: IDLE, FETCH, LOAD, PLOT, CLEAR, DONE.
- IDLE:
  - clear_req=1 goes to CLEAR, regardless of draw_req. Clear has priority when both requests are high.
  - Otherwise draw_req=1 goes to FETCH.
  - All request fields (col, row, char, fg, bg, clear_colour) are latched on the accept edge. Later input changes are ignored.
- Out-of-range draw (col>39 or row>29): the request is accepted, goes directly to DONE, and writes no pixels.
- FETCH: drive font_addr = {char, r}, where r is the glyph row counter 0..7.
- LOAD: latch font_data into an 8-bit shift register. Clear the pixel counter p.
- PLOT: 8 cycles, p = 0..7.
  - Write at x = col*8+p, y = row*8+r.
  - colour = fg if the shift-register MSB is 1, else bg. writeEn=1. Shift left each cycle.
  - After p=7: if r<7, increment r and go to FETCH; if r=7, go to DONE.
- CLEAR: raster scan, x 0..319 fastest, y 0..239.
  - One write per cycle with colour=clear_colour and writeEn=1.
  - After (319,239), go to DONE.
- DONE: done=1 for one cycle, then return to IDLE.
- Arithmetic: col*8 and row*8 are computed at 9 bits and never overflow (max 319 and 239). Clear counters wrap to 0 only on exit.

## Timing
- Reset values: state=IDLE, ready=1, done=0, writeEn=0, x=0, y=0, colour=0, font_addr=0. All internal counters are 0.
- x, y, colour and writeEn are registered. They are valid in the cycle the FSM is in PLOT or CLEAR. writeEn=0 in every other state.
- Glyph draw, accept edge at cycle 0:
  - FETCH in cycle 1; first write in cycle 3.
  - Each glyph row takes 10 cycles (FETCH, LOAD, 8×PLOT).
  - Last write in cycle 80; done in cycle 81; ready=1 in cycle 82.
- Clear: writes in cycles 1..76800; done in cycle 76801.
- Out-of-range draw: done in cycle 1.
- ready=0 from cycle 1 until the cycle after done. Requests asserted while ready=0 are ignored and are not queued.
- Reset asserted mid-operation: on the next edge the block returns to IDLE with writeEn=0. No done pulse is produced and the operation is discarded.

## Configuration
- TRANSPARENT_BG_EN defined: PLOT cycles whose glyph bit is 0 hold writeEn=0, so background pixels are left unchanged. Cycle counts are unchanged.
- TRANSPARENT_BG_EN undefined: every PLOT cycle writes, using bg for 0 bits.

## Test plan
- Reset, then draw col=0 row=0 char=0x41, fg=7 bg=0, with the ROM row for 'A' = 0x18 → 64 writes in cycles 3..80 at (0..7, 0..7); pixels x=3,4 of row 0 have colour 7, the rest 0; done at cycle 81.
- Draw col=39 row=29 → first write at (312,232), last at (319,239); font_addr sequence 0x0?0..7 matches {char, r}.
- draw_req and clear_req both high with clear_colour=4 → clear wins; 76800 writes of colour 4; last write at (319,239); done at cycle 76801; draw is dropped.
- Draw col=40 → no writeEn; done at cycle 1; ready=1 at cycle 2.
- Assert reset at cycle 40 of a draw → writeEn=0 and ready=1 the next cycle; no done pulse; a new draw is accepted normally afterwards.
- Build with TRANSPARENT_BG_EN and font_data=0x81 → exactly 2 writes per glyph row (p=0 and p=7); done still at cycle 81.
